// File: rtl/ux607_clic_gw_pkg.sv
// Shared types and helpers for the CLIC interrupt gateway.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package ux607_clic_gw_pkg;

  // Gateway handshake states
  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_REQ  = 2'd1,
    GW_SERV = 2'd2
  } gw_state_e;

  // Widest line vector the priority encoder handles
  localparam int GW_MAX_IRQ = 256;
  localparam int GW_ENC_W   = 8;

  // Minimum ID width able to name every line (at least one bit)
  function automatic int gw_id_w(input int irq_num);
    if (irq_num <= 2) return 1;
    return $clog2(irq_num);
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic logic [GW_ENC_W-1:0] gw_lowest_set(input logic [GW_MAX_IRQ-1:0] vec);
    logic [GW_ENC_W-1:0] idx;
    idx = '0;
    for (int i = GW_MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = GW_ENC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ux607_clic_irq_gate.sv
// One interrupt line: optional 2-flop sync, edge history and pending flop.
// Latency: raw line to pend is 3 cycles with SYNC=1, 1 cycle with SYNC=0.
// Backpressure: none; edge pending holds until cleared, further edges merge.
module ux607_clic_irq_gate #(
  parameter int SYNC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_line,
  input  logic trig,
  input  logic clr,
  output logic pend
);

  logic s;
  logic s_prev;
  logic trig_q;

  generate
    if (SYNC != 0) begin : g_sync
      logic [1:0] sync_q;

      // Two-stage synchroniser for lines coming from other clock domains
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], irq_line};
      end

      assign s = sync_q[1];
    end else begin : g_nosync
      assign s = irq_line;
    end
  endgenerate

  // Edge history, mode tracking and pending state; a mode change flushes pending
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev <= 1'b0;
      trig_q <= 1'b0;
      pend   <= 1'b0;
    end else begin
      s_prev <= s;
      trig_q <= trig;
      if (trig != trig_q) begin
        pend <= 1'b0;
      end else if (trig) begin
        // A new rising edge wins over a same-cycle clear
        pend <= (s & ~s_prev) | (pend & ~clr);
      end else begin
        pend <= s;
      end
    end
  end

endmodule

// File: rtl/ux607_clic_irq_gateway.sv
// CLIC gateway: per-line pending, fixed lowest-index priority, req/ack/done to core.
// Latency: line rise to irq_req is 4 cycles (SYNC=1) or 2 cycles (SYNC=0).
// Backpressure: one request held until ack or withdrawal; no nesting while in service.
module ux607_clic_irq_gateway
  import ux607_clic_gw_pkg::*;
#(
  parameter int IRQ_NUM = 50,
  parameter int ID_W    = 6,
  parameter int SYNC    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_NUM-1:0] clic_irq_i,
  input  logic [IRQ_NUM-1:0] irq_en,
  input  logic [IRQ_NUM-1:0] irq_trig,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_active,
  output logic [ID_W-1:0]    irq_act_id,
  output logic [IRQ_NUM-1:0] irq_pend
);

  localparam int ID_SPAN = 2 ** ID_W;

  generate
    if (ID_W < gw_id_w(IRQ_NUM)) begin : g_bad_id_w
      $error("ID_W too narrow to name every interrupt line");
    end
    if (IRQ_NUM > GW_MAX_IRQ) begin : g_bad_irq_num
      $error("IRQ_NUM exceeds priority encoder width");
    end
  endgenerate

  gw_state_e          state;
  logic [IRQ_NUM-1:0] pend;
  logic [IRQ_NUM-1:0] cand;
  logic [ID_SPAN-1:0] cand_span;
  logic [ID_W-1:0]    winner;
  logic               ack_fire;

  assign cand      = pend & irq_en;
  assign cand_span = ID_SPAN'(cand);
  assign winner    = ID_W'(gw_lowest_set(GW_MAX_IRQ'(cand)));
  assign ack_fire  = (state == GW_REQ) && irq_ack;
  assign irq_pend  = pend;

  generate
    for (genvar i = 0; i < IRQ_NUM; i++) begin : g_line
      ux607_clic_irq_gate #(
        .SYNC (SYNC)
      ) u_gate (
        .clk      (clk),
        .rst      (rst),
        .irq_line (clic_irq_i[i]),
        .trig     (irq_trig[i]),
        .clr      (ack_fire && (irq_id == ID_W'(i))),
        .pend     (pend[i])
      );
    end
  endgenerate

  // Handshake FSM: arbitrate in IDLE, hold the ID in REQ, block nesting in SERV
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GW_IDLE;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      irq_active <= 1'b0;
      irq_act_id <= '0;
    end else begin
      case (state)
        GW_IDLE: begin
          if (|cand) begin
            irq_id  <= winner;
            irq_req <= 1'b1;
            state   <= GW_REQ;
          end
        end
        GW_REQ: begin
          // Ack beats a same-cycle withdrawal
          if (irq_ack) begin
            irq_req    <= 1'b0;
            irq_active <= 1'b1;
            irq_act_id <= irq_id;
            state      <= GW_SERV;
          end else if (!cand_span[irq_id]) begin
            irq_req <= 1'b0;
            state   <= GW_IDLE;
          end
        end
        GW_SERV: begin
          if (irq_done) begin
            irq_active <= 1'b0;
            state      <= GW_IDLE;
          end
        end
        default: begin
          irq_req    <= 1'b0;
          irq_active <= 1'b0;
          state      <= GW_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ux607_clic_irq_gateway.sv
// Bench for the CLIC gateway: scoreboard of expected requests/claims with cycle stamps.
// Latency: checks 4-cycle request latency with SYNC=1 and handshake timing.
// Backpressure: exercises withdrawal, ack/withdraw race, no-nesting and reset.
module tb_ux607_clic_irq_gateway;

  localparam int IRQ_NUM = 50;
  localparam int ID_W    = 6;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [IRQ_NUM-1:0] clic_irq_i;
  logic [IRQ_NUM-1:0] irq_en;
  logic [IRQ_NUM-1:0] irq_trig;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               irq_done;
  logic               irq_active;
  logic [ID_W-1:0]    irq_act_id;
  logic [IRQ_NUM-1:0] irq_pend;

  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  exp_t req_q[$];
  exp_t act_q[$];
  logic prev_req = 1'b0;
  logic prev_act = 1'b0;

  ux607_clic_irq_gateway #(
    .IRQ_NUM (IRQ_NUM),
    .ID_W    (ID_W),
    .SYNC    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clic_irq_i (clic_irq_i),
    .irq_en     (irq_en),
    .irq_trig   (irq_trig),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .irq_active (irq_active),
    .irq_act_id (irq_act_id),
    .irq_pend   (irq_pend)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int id, input int at);
    exp_t e;
    e.id  = id;
    e.cyc = at;
    req_q.push_back(e);
  endtask

  task automatic do_ack(input int id);
    exp_t e;
    e.id  = id;
    e.cyc = cyc + 1;
    act_q.push_back(e);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!irq_req && n < 40) begin
      tick();
      n++;
    end
    chk(tag, irq_req, 1'b1);
  endtask

  // Scoreboard side: compare each new request / claim against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (irq_req === 1'b1 && !prev_req) begin
      if (req_q.size() == 0) begin
        chk("req_unexpected", irq_id, 0);
        chk("req_unexpected_flag", 1, 0);
      end else begin
        e = req_q.pop_front();
        chk("req_id", irq_id, e.id);
        chk("req_cycle", cyc, e.cyc);
      end
    end
    if (irq_active === 1'b1 && !prev_act) begin
      if (act_q.size() == 0) begin
        chk("act_unexpected", 1, 0);
      end else begin
        e = act_q.pop_front();
        chk("act_id", irq_act_id, e.id);
        chk("act_cycle", cyc, e.cyc);
      end
    end
    prev_req = (irq_req === 1'b1);
    prev_act = (irq_active === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst        = 1'b1;
    clic_irq_i = '0;
    irq_en     = '1;
    irq_en[12] = 1'b0;
    irq_trig   = '0;
    irq_trig[3]  = 1'b1;
    irq_trig[5]  = 1'b1;
    irq_trig[12] = 1'b1;
    irq_ack    = 1'b0;
    irq_done   = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_req", irq_req, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_active", irq_active, 0);
    chk("rst_act_id", irq_act_id, 0);
    chk("rst_pend", irq_pend, 0);
    rst = 1'b0;
    tick();
    tick();

    // Level line 7: request at +4, ack gives active next cycle
    clic_irq_i[7] = 1'b1;
    push_req(7, cyc + 4);
    wait_req("l7_req");
    do_ack(7);
    chk("l7_req_drop", irq_req, 0);
    clic_irq_i[7] = 1'b0;
    repeat (4) tick();
    pulse_done();
    chk("l7_done_inactive", irq_active, 0);
    repeat (3) tick();
    chk("l7_idle", irq_req, 0);

    // Lines 3 (edge) and 40 (level) together: 3 wins, 40 two cycles after done
    clic_irq_i[3]  = 1'b1;
    clic_irq_i[40] = 1'b1;
    push_req(3, cyc + 4);
    wait_req("p3_req");
    do_ack(3);
    clic_irq_i[3] = 1'b0;
    repeat (3) tick();
    chk("p3_no_nest", irq_req, 0);
    push_req(40, cyc + 2);
    pulse_done();
    wait_req("p40_req");
    do_ack(40);
    clic_irq_i[40] = 1'b0;
    repeat (4) tick();
    pulse_done();
    repeat (3) tick();

    // Edge line 12 latched while disabled, request after enable
    clic_irq_i[12] = 1'b1;
    tick();
    clic_irq_i[12] = 1'b0;
    repeat (5) tick();
    chk("e12_pend_disabled", irq_pend[12], 1);
    chk("e12_no_req", irq_req, 0);
    irq_en[12] = 1'b1;
    push_req(12, cyc + 1);
    wait_req("e12_req");
    do_ack(12);
    chk("e12_pend_cleared", irq_pend[12], 0);
    pulse_done();
    repeat (3) tick();

    // Level line 20 withdrawn before ack
    clic_irq_i[20] = 1'b1;
    push_req(20, cyc + 4);
    wait_req("w20_req");
    clic_irq_i[20] = 1'b0;
    repeat (3) tick();
    chk("w20_still_req", irq_req, 1);
    tick();
    chk("w20_withdrawn", irq_req, 0);
    chk("w20_not_active", irq_active, 0);
    repeat (4) tick();
    chk("w20_stays_idle", irq_req, 0);

    // Drop and ack in the same cycle: ack wins
    clic_irq_i[20] = 1'b1;
    push_req(20, cyc + 4);
    wait_req("r20_req");
    clic_irq_i[20] = 1'b0;
    repeat (3) tick();
    chk("r20_req_at_race", irq_req, 1);
    do_ack(20);
    chk("r20_active", irq_active, 1);
    pulse_done();
    repeat (3) tick();

    // Edge line 5: second edge during service is re-presented after done
    clic_irq_i[5] = 1'b1;
    push_req(5, cyc + 4);
    wait_req("e5_req");
    do_ack(5);
    clic_irq_i[5] = 1'b0;
    repeat (3) tick();
    chk("e5_pend_cleared", irq_pend[5], 0);
    clic_irq_i[5] = 1'b1;
    repeat (4) tick();
    chk("e5_pend_in_serv", irq_pend[5], 1);
    chk("e5_no_nest", irq_req, 0);
    clic_irq_i[5] = 1'b0;
    push_req(5, cyc + 2);
    pulse_done();
    wait_req("e5_represent");

    // Reset while requesting
    t = cyc;
    rst = 1'b1;
    tick();
    chk("mid_rst_cycle", cyc, t + 1);
    chk("mid_rst_req", irq_req, 0);
    chk("mid_rst_id", irq_id, 0);
    chk("mid_rst_active", irq_active, 0);
    chk("mid_rst_act_id", irq_act_id, 0);
    chk("mid_rst_pend", irq_pend, 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("post_rst_idle", irq_req, 0);

    chk("req_q_empty", req_q.size(), 0);
    chk("act_q_empty", act_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
